comparador_2b: RTL and testbench

- Registered 2-bit magnitude comparator.
- Operand X = {A,B} (A is MSB); operand Y = {C,D} (C is MSB).
- Produces one-hot flags: F1 = X>Y, F2 = X==Y, F3 = X<Y.
- Leaf block for datapath or control logic that needs the compare result in a registered, cycle-aligned form with a valid qualifier.

---
 rtl/comparador_2b_pkg.sv | 17 +
 rtl/comparador_2b_cmp_core.sv | 30 +++
 rtl/comparador_2b.sv | 60 ++++++
 tb/tb_comparador_2b.sv | 109 ++++++++++
 4 files changed

// File: rtl/comparador_2b_pkg.sv
// Shared result encoding for the registered 2-bit magnitude comparator.
// Results are ordered {F1,F2,F3} = {gt,eq,lt}.
package comparador_2b_pkg;

   typedef logic [2:0] cmp_res_t;

   localparam cmp_res_t CMP_GT   = 3'b100;
   localparam cmp_res_t CMP_EQ   = 3'b010;
   localparam cmp_res_t CMP_LT   = 3'b001;
   localparam cmp_res_t CMP_NONE = 3'b000;

   // Inverting the sign bit maps two's-complement order onto unsigned order.
   function automatic logic [1:0] cmp_bias(input logic [1:0] v, input logic is_signed);
      return {v[1] ^ is_signed, v[0]};
   endfunction

endpackage

// File: rtl/comparador_2b_cmp_core.sv
// Purely combinational 2-bit compare producing a one-hot {gt,eq,lt} result.
module comparador_2b_cmp_core
   import comparador_2b_pkg::*;
#(
   parameter bit SIGNED = 1'b0
) (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output cmp_res_t   res
);

   logic [1:0] x_b_s;
   logic [1:0] y_b_s;

   assign x_b_s = cmp_bias(x, SIGNED);
   assign y_b_s = cmp_bias(y, SIGNED);

   // Magnitude compare on the biased operands.
   always_comb begin
      res = CMP_NONE;
      if (x_b_s > y_b_s) begin
         res = CMP_GT;
      end else if (x_b_s == y_b_s) begin
         res = CMP_EQ;
      end else begin
         res = CMP_LT;
      end
   end

endmodule

// File: rtl/comparador_2b.sv
// Registered 2-bit magnitude comparator, X={A,B} vs Y={C,D}, one-cycle latency.
// Flags hold their last value while no qualified sample arrives.
module comparador_2b
   import comparador_2b_pkg::*;
#(
   parameter bit SIGNED = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D,
   output logic out_valid,
   output logic F1,
   output logic F2,
   output logic F3
);

   cmp_res_t core_res_s;
   cmp_res_t res_d;
   cmp_res_t res_q;
   logic     valid_d;
   logic     valid_q;

   comparador_2b_cmp_core #(
      .SIGNED (SIGNED)
   ) u_cmp_core (
      .x   ({A, B}),
      .y   ({C, D}),
      .res (core_res_s)
   );

   // Next-state: reset wins over a qualified sample; otherwise hold.
   always_comb begin
      res_d   = res_q;
      valid_d = 1'b0;
      if (rst) begin
         res_d   = CMP_NONE;
         valid_d = 1'b0;
      end else if (in_valid) begin
         res_d   = core_res_s;
         valid_d = 1'b1;
      end else begin
         res_d   = res_q;
         valid_d = 1'b0;
      end
   end

   // Result and valid registers.
   always_ff @(posedge clk) begin
      res_q   <= res_d;
      valid_q <= valid_d;
   end

   assign out_valid    = valid_q;
   assign {F1, F2, F3} = res_q;

endmodule

// File: tb/tb_comparador_2b.sv
// Directed bench for comparador_2b: one unsigned and one signed instance share stimulus.
module tb_comparador_2b;
   import comparador_2b_pkg::*;

   typedef struct packed {
      logic       rst;
      logic       vld;
      logic [3:0] abcd;
      logic       ev;
      logic [2:0] eu;
      logic [2:0] es;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
   logic ov_u, f1_u, f2_u, f3_u;
   logic ov_s, f1_s, f2_s, f3_s;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   comparador_2b #(.SIGNED(1'b0)) dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .A(A), .B(B), .C(C), .D(D),
      .out_valid(ov_u), .F1(f1_u), .F2(f2_u), .F3(f3_u)
   );

   comparador_2b #(.SIGNED(1'b1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .A(A), .B(B), .C(C), .D(D),
      .out_valid(ov_s), .F1(f1_s), .F2(f2_s), .F3(f3_s)
   );

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one vector, clock it in, then compare both instances just after the edge.
   task automatic apply(input vec_t v, input string tag);
      rst      = v.rst;
      in_valid = v.vld;
      {A, B, C, D} = v.abcd;
      @(posedge clk);
      #1;
      check({tag, " valid_u"}, {2'b00, ov_u}, {2'b00, v.ev});
      check({tag, " valid_s"}, {2'b00, ov_s}, {2'b00, v.ev});
      check({tag, " flags_u"}, {f1_u, f2_u, f3_u}, v.eu);
      check({tag, " flags_s"}, {f1_s, f2_s, f3_s}, v.es);
      if (v.ev) begin
         check({tag, " onehot_u"}, 3'($countones({f1_u, f2_u, f3_u})), 3'd1);
         check({tag, " onehot_s"}, 3'($countones({f1_s, f2_s, f3_s})), 3'd1);
      end
   endtask

   vec_t tbl[$];

   initial begin
      // Reset held with a live sample presented.
      for (int i = 0; i < 3; i++)
         tbl.push_back('{1'b1, 1'b1, 4'b1100, 1'b0, CMP_NONE, CMP_NONE});
      // Sweep of all 16 {A,B,C,D}: expected unsigned / signed results.
      tbl.push_back('{1'b0, 1'b1, 4'b0000, 1'b1, CMP_EQ, CMP_EQ});
      tbl.push_back('{1'b0, 1'b1, 4'b0001, 1'b1, CMP_LT, CMP_LT});
      tbl.push_back('{1'b0, 1'b1, 4'b0010, 1'b1, CMP_LT, CMP_GT});
      tbl.push_back('{1'b0, 1'b1, 4'b0011, 1'b1, CMP_LT, CMP_GT});
      tbl.push_back('{1'b0, 1'b1, 4'b0100, 1'b1, CMP_GT, CMP_GT});
      tbl.push_back('{1'b0, 1'b1, 4'b0101, 1'b1, CMP_EQ, CMP_EQ});
      tbl.push_back('{1'b0, 1'b1, 4'b0110, 1'b1, CMP_LT, CMP_GT});
      tbl.push_back('{1'b0, 1'b1, 4'b0111, 1'b1, CMP_LT, CMP_GT});
      tbl.push_back('{1'b0, 1'b1, 4'b1000, 1'b1, CMP_GT, CMP_LT});
      tbl.push_back('{1'b0, 1'b1, 4'b1001, 1'b1, CMP_GT, CMP_LT});
      tbl.push_back('{1'b0, 1'b1, 4'b1010, 1'b1, CMP_EQ, CMP_EQ});
      tbl.push_back('{1'b0, 1'b1, 4'b1011, 1'b1, CMP_LT, CMP_LT});
      tbl.push_back('{1'b0, 1'b1, 4'b1100, 1'b1, CMP_GT, CMP_LT});
      tbl.push_back('{1'b0, 1'b1, 4'b1101, 1'b1, CMP_GT, CMP_LT});
      tbl.push_back('{1'b0, 1'b1, 4'b1110, 1'b1, CMP_GT, CMP_GT});
      tbl.push_back('{1'b0, 1'b1, 4'b1111, 1'b1, CMP_EQ, CMP_EQ});

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("vec%0d", i));

      // Hold: 0100 gives GT in both modes, then four idle cycles with changing inputs.
      apply('{1'b0, 1'b1, 4'b0100, 1'b1, CMP_GT, CMP_GT}, "hold_load");
      apply('{1'b0, 1'b0, 4'b0000, 1'b0, CMP_GT, CMP_GT}, "hold_idle0");
      apply('{1'b0, 1'b0, 4'b1111, 1'b0, CMP_GT, CMP_GT}, "hold_idle1");
      apply('{1'b0, 1'b0, 4'b0101, 1'b0, CMP_GT, CMP_GT}, "hold_idle2");
      apply('{1'b0, 1'b0, 4'b1010, 1'b0, CMP_GT, CMP_GT}, "hold_idle3");

      // Mid-stream reset discards the sample presented with it.
      apply('{1'b0, 1'b1, 4'b0001, 1'b1, CMP_LT, CMP_LT}, "mid_first");
      apply('{1'b1, 1'b1, 4'b0100, 1'b0, CMP_NONE, CMP_NONE}, "mid_rst");
      apply('{1'b0, 1'b1, 4'b0101, 1'b1, CMP_EQ, CMP_EQ}, "mid_after");

      // Idle after reset-free stream: valid drops, EQ retained.
      apply('{1'b0, 1'b0, 4'b1100, 1'b0, CMP_EQ, CMP_EQ}, "tail_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
